// File: rtl/mem_stage_pkg.sv
// Shared LC-3b types for the MEM stage: word/register widths, opcodes,
// the MEM sequencing states and opcode classification helpers.
package mem_stage_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PTR   = 2'd1,
    S_FINAL = 2'd2
  } lc3b_mem_state;

  // Opcodes that touch data memory (TRAP reads its vector).
  function automatic logic is_mem_op(lc3b_opcode op);
    return (op == op_ldr) || (op == op_ldb) || (op == op_ldi) ||
           (op == op_str) || (op == op_stb) || (op == op_sti) ||
           (op == op_trap);
  endfunction

  // Two-access ops: first read fetches a pointer, second access uses it.
  function automatic logic is_indirect(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/mem_stage_byte_fmt.sv
// Byte formatting for the MEM stage: LDB lane select with sign extension,
// STB byte replication and write lane enables. Purely combinational.
module mem_byte_fmt
  import mem_stage_pkg::*;
(
  input  logic       addr_lsb_i,
  input  lc3b_word   rdata_i,
  input  lc3b_word   sr2_i,
  output lc3b_word   ldb_result_o,
  output lc3b_word   stb_wdata_o,
  output logic [1:0] stb_be_o
);

  logic signed [7:0] ld_byte;

  // Pick the addressed byte lane for loads and steer the store byte to both lanes.
  always_comb begin
    ld_byte      = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
    ldb_result_o = {{8{ld_byte[7]}}, ld_byte};
    stb_wdata_o  = {sr2_i[7:0], sr2_i[7:0]};
    stb_be_o     = addr_lsb_i ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b pipeline MEM stage: drives the data-memory port, sequences the
// LDI/STI pointer access, formats byte accesses and stalls while busy.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       exmem_valid,
  input  lc3b_opcode exmem_opcode,
  input  lc3b_word   exmem_alu,
  input  lc3b_word   exmem_sr2,
  input  lc3b_word   exmem_branch_address,
  input  lc3b_reg    exmem_rd,
  input  lc3b_word   dmem_rdata,
  input  logic       dmem_resp,
  output lc3b_word   dmem_address,
  output logic       dmem_read,
  output logic       dmem_write,
  output logic [1:0] dmem_byte_enable,
  output lc3b_word   dmem_wdata,
  output lc3b_word   mem_result,
  output lc3b_reg    mem_rd,
  output logic       mem_stall
);

  lc3b_mem_state state_q, state_d;
  lc3b_word      ptr_q, ptr_d;

  logic       mem_op;
  logic       rd_strobe;
  logic       wr_strobe;
  logic       final_acc;
  lc3b_word   ldb_result;
  lc3b_word   stb_wdata;
  logic [1:0] stb_be;

  assign mem_op = exmem_valid && is_mem_op(exmem_opcode);
  assign mem_rd = exmem_rd;

  mem_byte_fmt u_byte_fmt (
    .addr_lsb_i   (exmem_alu[0]),
    .rdata_i      (dmem_rdata),
    .sr2_i        (exmem_sr2),
    .ldb_result_o (ldb_result),
    .stb_wdata_o  (stb_wdata),
    .stb_be_o     (stb_be)
  );

  // State and pointer register; reset abandons any in-flight indirect access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state plus memory port decode from the current state and opcode.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    rd_strobe        = 1'b0;
    wr_strobe        = 1'b0;
    final_acc        = 1'b0;
    dmem_address     = exmem_alu;
    dmem_byte_enable = 2'b11;
    dmem_wdata       = exmem_sr2;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (is_indirect(exmem_opcode)) begin
            rd_strobe = 1'b1;
            if (dmem_resp) begin
              ptr_d   = dmem_rdata;
              state_d = S_PTR;
            end
          end else begin
            final_acc = 1'b1;
            if (exmem_opcode == op_str) begin
              wr_strobe = 1'b1;
            end else if (exmem_opcode == op_stb) begin
              wr_strobe        = 1'b1;
              dmem_byte_enable = stb_be;
              dmem_wdata       = stb_wdata;
            end else begin
              rd_strobe = 1'b1;
            end
          end
        end
      end
      // Turnaround cycle between pointer read and final access; no strobes.
      S_PTR: begin
        dmem_address = ptr_q;
        state_d      = S_FINAL;
      end
      S_FINAL: begin
        dmem_address = ptr_q;
        final_acc    = 1'b1;
        if (exmem_opcode == op_sti) wr_strobe = 1'b1;
        else                        rd_strobe = 1'b1;
        if (dmem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and stall are suppressed during reset; stall clears on the completing resp.
  always_comb begin
    dmem_read  = rd_strobe && !reset;
    dmem_write = wr_strobe && !reset;
    mem_stall  = !reset && (mem_op || (state_q != S_IDLE)) &&
                 !(final_acc && dmem_resp);
  end

  // Writeback value: formatted load data, LEA address, or the ALU result.
  always_comb begin
    mem_result = exmem_alu;
    if (mem_op) begin
      case (exmem_opcode)
        op_ldb:                 mem_result = ldb_result;
        op_ldr, op_ldi, op_trap: mem_result = dmem_rdata;
        default:                mem_result = exmem_alu;
      endcase
    end else if (exmem_valid && exmem_opcode == op_lea) begin
      mem_result = exmem_branch_address;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expectations.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic       clk;
  logic       reset;
  logic       exmem_valid;
  lc3b_opcode exmem_opcode;
  lc3b_word   exmem_alu;
  lc3b_word   exmem_sr2;
  lc3b_word   exmem_branch_address;
  lc3b_reg    exmem_rd;
  lc3b_word   dmem_rdata;
  logic       dmem_resp;
  lc3b_word   dmem_address;
  logic       dmem_read;
  logic       dmem_write;
  logic [1:0] dmem_byte_enable;
  lc3b_word   dmem_wdata;
  lc3b_word   mem_result;
  lc3b_reg    mem_rd;
  logic       mem_stall;

  int ntests = 0;
  int nfails = 0;

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .exmem_valid          (exmem_valid),
    .exmem_opcode         (exmem_opcode),
    .exmem_alu            (exmem_alu),
    .exmem_sr2            (exmem_sr2),
    .exmem_branch_address (exmem_branch_address),
    .exmem_rd             (exmem_rd),
    .dmem_rdata           (dmem_rdata),
    .dmem_resp            (dmem_resp),
    .dmem_address         (dmem_address),
    .dmem_read            (dmem_read),
    .dmem_write           (dmem_write),
    .dmem_byte_enable     (dmem_byte_enable),
    .dmem_wdata           (dmem_wdata),
    .mem_result           (mem_result),
    .mem_rd               (mem_rd),
    .mem_stall            (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to a point 2ns after the next rising edge; inputs change here.
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input lc3b_opcode op, input lc3b_word alu,
                        input lc3b_word sr2, input lc3b_word rdata, input logic resp);
    exmem_valid  = v;
    exmem_opcode = op;
    exmem_alu    = alu;
    exmem_sr2    = sr2;
    dmem_rdata   = rdata;
    dmem_resp    = resp;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    exmem_branch_address = 16'h0000;
    exmem_rd = 3'd0;
    set_in(1'b1, op_ldr, 16'h0040, 16'h0000, 16'h1111, 1'b0);
    next_cyc();
    next_cyc();
    #1;
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b000) begin
      nfails++;
      $display("FAIL reset_strobes: got r/w/s=%b required 000", {dmem_read, dmem_write, mem_stall});
    end
    ntests++;
    if (mem_result !== 16'h1111) begin
      nfails++;
      $display("FAIL reset_result_comb: got %h required 1111", mem_result);
    end
    set_in(1'b0, op_add, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    next_cyc();
    reset = 1'b0;
  endtask

  task automatic test_nonmem();
    exmem_rd = 3'd5;
    set_in(1'b1, op_add, 16'h1234, 16'h0000, 16'hAAAA, 1'b0);
    ntests++;
    if (mem_result !== 16'h1234 || {dmem_read, dmem_write, mem_stall} !== 3'b000) begin
      nfails++;
      $display("FAIL add_passthru: got res=%h rws=%b required 1234 000", mem_result, {dmem_read, dmem_write, mem_stall});
    end
    ntests++;
    if (mem_rd !== 3'd5) begin
      nfails++;
      $display("FAIL rd_passthru: got %0d required 5", mem_rd);
    end
    exmem_branch_address = 16'h3000;
    set_in(1'b1, op_lea, 16'h1234, 16'h0000, 16'hAAAA, 1'b0);
    ntests++;
    if (mem_result !== 16'h3000 || mem_stall !== 1'b0) begin
      nfails++;
      $display("FAIL lea_result: got res=%h stall=%b required 3000 0", mem_result, mem_stall);
    end
    set_in(1'b0, op_ldr, 16'h0040, 16'h0000, 16'hAAAA, 1'b1);
    ntests++;
    if (mem_result !== 16'h0040 || {dmem_read, dmem_write, mem_stall} !== 3'b000) begin
      nfails++;
      $display("FAIL invalid_ldr: got res=%h rws=%b required 0040 000", mem_result, {dmem_read, dmem_write, mem_stall});
    end
    next_cyc();
  endtask

  task automatic test_ldr_wait();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, op_ldr, 16'h0040, 16'h0000, 16'h0000, 1'b0);
      ntests++;
      if ({dmem_read, dmem_write, mem_stall} !== 3'b101 || dmem_address !== 16'h0040) begin
        nfails++;
        $display("FAIL ldr_wait_%0d: got rws=%b addr=%h required 101 0040", i, {dmem_read, dmem_write, mem_stall}, dmem_address);
      end
      next_cyc();
    end
    set_in(1'b1, op_ldr, 16'h0040, 16'h0000, 16'hBEEF, 1'b1);
    ntests++;
    if ({dmem_read, mem_stall} !== 2'b10 || mem_result !== 16'hBEEF) begin
      nfails++;
      $display("FAIL ldr_resp: got rs=%b res=%h required 10 BEEF", {dmem_read, mem_stall}, mem_result);
    end
    next_cyc();
    set_in(1'b0, op_add, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_ldb();
    set_in(1'b1, op_ldb, 16'h0041, 16'h0000, 16'h80FF, 1'b1);
    ntests++;
    if (mem_result !== 16'hFF80 || mem_stall !== 1'b0 || dmem_read !== 1'b1) begin
      nfails++;
      $display("FAIL ldb_hi: got res=%h stall=%b rd=%b required FF80 0 1", mem_result, mem_stall, dmem_read);
    end
    next_cyc();
    set_in(1'b1, op_ldb, 16'h0040, 16'h0000, 16'h80FF, 1'b1);
    ntests++;
    if (mem_result !== 16'hFFFF) begin
      nfails++;
      $display("FAIL ldb_lo: got %h required FFFF", mem_result);
    end
    next_cyc();
    set_in(1'b1, op_ldb, 16'h0040, 16'h0000, 16'h807F, 1'b1);
    ntests++;
    if (mem_result !== 16'h007F) begin
      nfails++;
      $display("FAIL ldb_pos: got %h required 007F", mem_result);
    end
    next_cyc();
    set_in(1'b0, op_add, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_stores();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, op_stb, 16'h0043, 16'h12AB, 16'h0000, 1'b0);
      ntests++;
      if ({dmem_read, dmem_write, mem_stall} !== 3'b011 || dmem_byte_enable !== 2'b10 ||
          dmem_wdata !== 16'hABAB || dmem_address !== 16'h0043) begin
        nfails++;
        $display("FAIL stb_hold_%0d: got rws=%b be=%b wd=%h addr=%h required 011 10 ABAB 0043", i,
                 {dmem_read, dmem_write, mem_stall}, dmem_byte_enable, dmem_wdata, dmem_address);
      end
      next_cyc();
    end
    set_in(1'b1, op_stb, 16'h0042, 16'h12AB, 16'h0000, 1'b1);
    ntests++;
    if ({dmem_write, mem_stall} !== 2'b10 || dmem_byte_enable !== 2'b01) begin
      nfails++;
      $display("FAIL stb_even_resp: got ws=%b be=%b required 10 01", {dmem_write, mem_stall}, dmem_byte_enable);
    end
    next_cyc();
    set_in(1'b1, op_str, 16'h0044, 16'h12AB, 16'h0000, 1'b1);
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b010 || dmem_byte_enable !== 2'b11 || dmem_wdata !== 16'h12AB) begin
      nfails++;
      $display("FAIL str_word: got rws=%b be=%b wd=%h required 010 11 12AB",
               {dmem_read, dmem_write, mem_stall}, dmem_byte_enable, dmem_wdata);
    end
    next_cyc();
    set_in(1'b0, op_add, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_indirect(input lc3b_opcode op);
    logic exp_rd;
    exp_rd = (op == op_ldi);
    set_in(1'b1, op, 16'h0100, 16'hCAFE, 16'h0000, 1'b0);
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b101 || dmem_address !== 16'h0100) begin
      nfails++;
      $display("FAIL %s_ptr_rd: got rws=%b addr=%h required 101 0100", op.name(), {dmem_read, dmem_write, mem_stall}, dmem_address);
    end
    next_cyc();
    set_in(1'b1, op, 16'h0100, 16'hCAFE, 16'h0200, 1'b1);
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b101) begin
      nfails++;
      $display("FAIL %s_ptr_resp: got rws=%b required 101", op.name(), {dmem_read, dmem_write, mem_stall});
    end
    next_cyc();
    set_in(1'b1, op, 16'h0100, 16'hCAFE, 16'h0000, 1'b1);
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b001) begin
      nfails++;
      $display("FAIL %s_gap: got rws=%b required 001", op.name(), {dmem_read, dmem_write, mem_stall});
    end
    next_cyc();
    set_in(1'b1, op, 16'h0100, 16'hCAFE, 16'h0000, 1'b0);
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== {exp_rd, !exp_rd, 1'b1} || dmem_address !== 16'h0200) begin
      nfails++;
      $display("FAIL %s_final_wait: got rws=%b addr=%h required %b 0200", op.name(),
               {dmem_read, dmem_write, mem_stall}, dmem_address, {exp_rd, !exp_rd, 1'b1});
    end
    if (op == op_sti) return;
    next_cyc();
    set_in(1'b1, op, 16'h0100, 16'hCAFE, 16'h5555, 1'b1);
    ntests++;
    if (mem_stall !== 1'b0 || mem_result !== 16'h5555 || dmem_read !== 1'b1) begin
      nfails++;
      $display("FAIL ldi_final_resp: got stall=%b res=%h rd=%b required 0 5555 1", mem_stall, mem_result, dmem_read);
    end
    next_cyc();
    set_in(1'b0, op_add, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_sti_reset();
    test_indirect(op_sti);
    ntests++;
    if (dmem_wdata !== 16'hCAFE || dmem_byte_enable !== 2'b11) begin
      nfails++;
      $display("FAIL sti_wdata: got wd=%h be=%b required CAFE 11", dmem_wdata, dmem_byte_enable);
    end
    next_cyc();
    reset = 1'b1;
    #1;
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b000) begin
      nfails++;
      $display("FAIL sti_reset_strobes: got rws=%b required 000", {dmem_read, dmem_write, mem_stall});
    end
    next_cyc();
    reset = 1'b0;
    set_in(1'b0, op_add, 16'h0000, 16'h0000, 16'h7777, 1'b1);
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b000) begin
      nfails++;
      $display("FAIL stray_resp: got rws=%b required 000", {dmem_read, dmem_write, mem_stall});
    end
    next_cyc();
    set_in(1'b1, op_sti, 16'h0300, 16'hCAFE, 16'h0000, 1'b0);
    ntests++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b101 || dmem_address !== 16'h0300) begin
      nfails++;
      $display("FAIL post_reset_idle: got rws=%b addr=%h required 101 0300", {dmem_read, dmem_write, mem_stall}, dmem_address);
    end
    next_cyc();
    set_in(1'b0, op_add, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_ldr_wait();
    test_ldb();
    test_stores();
    test_indirect(op_ldi);
    test_sti_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfails);
    $finish;
  end

endmodule
